// File: rtl/axil_regbank_pkg.sv
// Shared response codes, channel state encodings and address-index helper
// for the AXI4-Lite register bank.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic int idx_width(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axil_regbank_wr.sv
// Write channel of the register bank: AW/W capture in any order, byte-strobed
// commit into the RW register array, B response and per-register write pulses.
module axil_regbank_wr
  import axil_regbank_pkg::*;
#(
  parameter int                DW        = 32,
  parameter int                AW        = 5,
  parameter int                NUM_REGS  = 8,
  parameter logic [63:0]       RO_MASK   = '0,
  parameter logic [DW-1:0]     RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW-1:0]           awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DW-1:0]           wdata,
  input  logic [DW/8-1:0]         wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [NUM_REGS*DW-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     wr_pulse
);

  localparam int OFF_W = $clog2(DW / 8);
  localparam int IDX_W = idx_width(AW, DW);

  wr_state_e         state;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     data_q;
  logic [DW/8-1:0]   strb_q;
  logic              aw_got, w_got;
  logic [DW-1:0]     regs [NUM_REGS];

  logic              aw_hs, w_hs, aw_have, w_have;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_data;
  logic [DW/8-1:0]   c_strb;
  logic [IDX_W-1:0]  c_idx;
  logic              in_range, tgt_ro;
  logic              unused_lo;

  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign aw_have = aw_hs | aw_got;
  assign w_have  = w_hs | w_got;

  // A beat arriving on this very edge takes priority over the latched copy,
  // so same-cycle AW+W commits without an extra bubble.
  assign c_addr    = aw_hs ? awaddr : addr_q;
  assign c_data    = w_hs ? wdata : data_q;
  assign c_strb    = w_hs ? wstrb : strb_q;
  assign c_idx     = c_addr[AW-1:OFF_W];
  assign unused_lo = ^c_addr[OFF_W-1:0];
  assign in_range  = int'(c_idx) < NUM_REGS;

  always_comb begin
    tgt_ro = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (int'(c_idx) == n) tgt_ro = RO_MASK[n];
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) addr_q <= awaddr;
    if (w_hs) begin
      data_q <= wdata;
      strb_q <= wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= '0;
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= RESET_VAL;
    end else begin
      wr_pulse <= '0;
      case (state)
        W_IDLE: begin
          if (aw_have && w_have) begin
            state   <= W_RESP;
            bvalid  <= 1'b1;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            if (!in_range) begin
              bresp <= RESP_SLVERR;
            end else begin
              bresp <= RESP_OKAY;
              for (int n = 0; n < NUM_REGS; n++) begin
                if (int'(c_idx) == n && !tgt_ro) begin
                  wr_pulse[n] <= 1'b1;
                  for (int b = 0; b < DW / 8; b++) begin
                    if (c_strb[b]) regs[n][b*8 +: 8] <= c_data[b*8 +: 8];
                  end
                end
              end
            end
          end else begin
            aw_got  <= aw_have;
            w_got   <= w_have;
            awready <= !aw_have;
            wready  <= !w_have;
          end
        end
        W_RESP: begin
          if (bready) begin
            state   <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  // Read-only slots never expose their (unused) storage.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DW +: DW] = RO_MASK[g] ? '0 : regs[g];
  end

endmodule

// File: rtl/axil_regbank_s.sv
// AXI4-Lite slave register bank: parametrised RW/RO register array with
// byte strobes, write pulses and SLVERR on out-of-range accesses.
module axil_regbank_s
  import axil_regbank_pkg::*;
#(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 5,
  parameter int                            C_NUM_REGS         = 8,
  parameter logic [63:0]                   C_RO_MASK          = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_RESET_VAL        = '0
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_i,
  output logic [C_NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int OFF_W = $clog2(DW / 8);
  localparam int IDX_W = idx_width(AW, DW);

  rd_state_e         rstate;
  logic [IDX_W-1:0]  ar_idx;
  logic              rd_in_range;
  logic [DW-1:0]     rd_hit_data;
  logic              unused_misc;

  assign unused_misc = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[OFF_W-1:0]};

  axil_regbank_wr #(
    .DW        (DW),
    .AW        (AW),
    .NUM_REGS  (C_NUM_REGS),
    .RO_MASK   (C_RO_MASK),
    .RESET_VAL (C_RESET_VAL)
  ) u_wr (
    .clk      (S_AXI_ACLK),
    .rst      (S_AXI_ARESET),
    .awaddr   (S_AXI_AWADDR),
    .awvalid  (S_AXI_AWVALID),
    .awready  (S_AXI_AWREADY),
    .wdata    (S_AXI_WDATA),
    .wstrb    (S_AXI_WSTRB),
    .wvalid   (S_AXI_WVALID),
    .wready   (S_AXI_WREADY),
    .bresp    (S_AXI_BRESP),
    .bvalid   (S_AXI_BVALID),
    .bready   (S_AXI_BREADY),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  assign ar_idx      = S_AXI_ARADDR[AW-1:OFF_W];
  assign rd_in_range = int'(ar_idx) < C_NUM_REGS;

  // reg_q is the registered array, so a read racing a write sees the old value.
  always_comb begin
    rd_hit_data = '0;
    for (int n = 0; n < C_NUM_REGS; n++) begin
      if (int'(ar_idx) == n)
        rd_hit_data = C_RO_MASK[n] ? status_i[n*DW +: DW] : reg_q[n*DW +: DW];
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rstate        <= R_DATA;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_in_range ? rd_hit_data : '0;
            S_AXI_RRESP   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rstate        <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_regbank_s.sv
// Scoreboard bench for axil_regbank_s: directed AXI4-Lite traffic with
// expected B/R responses queued at issue and checked by independent monitors.
module tb_axil_regbank_s;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam logic [63:0] RO  = 64'h80;
  localparam logic [31:0] RST = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [2:0]      awprot = 3'd0, arprot = 3'd0;
  logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic            bready = 1'b1, rready = 1'b1;
  logic [DW-1:0]   wdata = '0;
  logic [3:0]      wstrb = '0;
  logic            awready, wready, arready, bvalid, rvalid;
  logic [1:0]      bresp, rresp;
  logic [DW-1:0]   rdata;
  logic [NR*DW-1:0] reg_q;
  logic [NR*DW-1:0] status = '0;
  logic [NR-1:0]   wr_pulse;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int         pulse_cnt [NR];
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  axil_regbank_s #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_NUM_REGS         (NR),
    .C_RO_MASK          (RO),
    .C_RESET_VAL        (RST)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_q         (reg_q),
    .status_i      (status),
    .wr_pulse      (wr_pulse)
  );

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare on each completed B/R handshake.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bresp, exp_b.pop_front());
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        rexp_t e;
        e = exp_r.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
      end
    end
    if (wr_pulse != '0) chk("pulse_with_bvalid", bvalid, 1);
    for (int n = 0; n < NR; n++) if (wr_pulse[n]) pulse_cnt[n]++;
  end

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] eresp);
    logic aw_acc, w_acc;
    exp_b.push_back(eresp);
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_acc) awvalid = 1'b0;
      if (w_acc)  wvalid  = 1'b0;
    end
    chk("write_handshake_done", {awvalid, wvalid}, 0);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] eresp, input bit push);
    logic ar_acc;
    if (push) exp_r.push_back('{data: d, resp: eresp});
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50 && arvalid; i++) begin
      @(negedge clk);
      ar_acc = arvalid && arready;
      @(posedge clk); #1;
      if (ar_acc) arvalid = 1'b0;
    end
    chk("read_handshake_done", arvalid, 0);
    arvalid = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < NR; n++) pulse_cnt[n] = 0;
    status[7*DW +: DW] = 32'hDEAD_BEEF;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg0", reg_q[0 +: DW], RST);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", {awready, wready, arready}, 3'b111);

    // Basic write/readback
    axi_write(6'h00, 32'h1, 4'hF, 2'b00);
    axi_write(6'h04, 32'h2, 4'hF, 2'b00);
    axi_write(6'h08, 32'h3, 4'hF, 2'b00);
    axi_write(6'h0C, 32'h4, 4'hF, 2'b00);
    axi_read(6'h00, 32'h1, 2'b00, 1);
    axi_read(6'h04, 32'h2, 2'b00, 1);
    axi_read(6'h08, 32'h3, 2'b00, 1);
    axi_read(6'h0C, 32'h4, 2'b00, 1);
    axi_read(6'h14, RST, 2'b00, 1);

    // Byte strobes
    axi_write(6'h10, 32'h1122_3344, 4'hF, 2'b00);
    axi_write(6'h10, 32'hAABB_CCDD, 4'b0010, 2'b00);
    axi_read(6'h10, 32'h1122_CC44, 2'b00, 1);

    // Read-only slot 7
    axi_write(6'h1C, 32'h5, 4'hF, 2'b00);
    axi_read(6'h1C, 32'hDEAD_BEEF, 2'b00, 1);
    chk("ro_regq_zero", reg_q[7*DW +: DW], 0);

    // Out of range
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 2'b10);
    axi_read(6'h20, 32'h0, 2'b10, 1);
    axi_read(6'h3C, 32'h0, 2'b10, 1);
    chk("oor_reg0_kept", reg_q[0 +: DW], 32'h1);
    chk("oor_reg4_kept", reg_q[4*DW +: DW], 32'h1122_CC44);

    // Zero strobe: OKAY, unchanged, pulse still fires
    axi_write(6'h04, 32'hFFFF_FFFF, 4'h0, 2'b00);
    axi_read(6'h04, 32'h2, 2'b00, 1);

    // W leads AW by 3 cycles, BREADY held low 5 cycles
    repeat (3) @(posedge clk);
    #1 bready = 1'b0;
    exp_b.push_back(2'b00);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); chk("lead_wready", wready, 1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    chk("w_latched_wready", wready, 0);
    chk("w_latched_awready", awready, 1);
    repeat (3) @(posedge clk);
    #1 awaddr = 6'h08; awvalid = 1'b1;
    @(negedge clk); chk("lag_awready", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_bvalid", bvalid, 1);
      chk("held_readies", {awready, wready}, 2'b00);
    end
    @(posedge clk); #1 bready = 1'b1;
    axi_read(6'h08, 32'h77, 2'b00, 1);

    // Simultaneous write and read to the same register
    repeat (3) @(posedge clk);
    #1;
    exp_b.push_back(2'b00);
    exp_r.push_back('{data: 32'h4, resp: 2'b00});
    awaddr = 6'h0C; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 6'h0C; arvalid = 1'b1;
    @(negedge clk); chk("simul_readies", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    axi_read(6'h0C, 32'h99, 2'b00, 1);

    // Reset while RVALID held
    repeat (3) @(posedge clk);
    #1 rready = 1'b0;
    axi_read(6'h00, 32'h0, 2'b00, 0);
    for (int i = 0; i < 10 && !rvalid; i++) @(negedge clk);
    chk("rvalid_before_reset", rvalid, 1);
    @(negedge clk); #1 rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_arready", arready, 0);
    chk("rst_mid_reg0", reg_q[0 +: DW], RST);
    chk("rst_mid_reg3", reg_q[3*DW +: DW], RST);
    @(posedge clk); #1 rst = 1'b0; rready = 1'b1;
    axi_read(6'h00, RST, 2'b00, 1);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    chk("pulse_r0", pulse_cnt[0], 1);
    chk("pulse_r1", pulse_cnt[1], 2);
    chk("pulse_r2", pulse_cnt[2], 2);
    chk("pulse_r3", pulse_cnt[3], 2);
    chk("pulse_r4", pulse_cnt[4], 2);
    chk("pulse_r5", pulse_cnt[5], 0);
    chk("pulse_r6", pulse_cnt[6], 0);
    chk("pulse_r7", pulse_cnt[7], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_regbank_s.md
# axil_regbank_s

AXI4-Lite slave register bank; parametrised successor to the fixed four-register user-IP slave. Provides C_NUM_REGS word registers with byte strobes, per-register read-only status mapping, per-register write pulses and SLVERR on out-of-range access. Sits behind the interconnect as the control/status port of user IP and is exercised by the master VIP agent bench.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; 32 or 64.
- C_S_AXI_ADDR_WIDTH, 5: byte address width; must be ≥ clog2(C_NUM_REGS)+clog2(DW/8).
- C_NUM_REGS, 8: number of registers, 1..64.
- C_RO_MASK, 0: bit n = 1 makes register n read-only; its reads return status_i slice n.
- C_RESET_VAL, 0: reset value applied to every RW register.

- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  AW/3/1; S_AXI_AWREADY out 1.
- S_AXI_WDATA/WSTRB/WVALID  in  DW/DW/8/1; S_AXI_WREADY out 1.
- S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY in 1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  AW/3/1; S_AXI_ARREADY out 1.
- S_AXI_RDATA/RRESP/RVALID  out  DW/2/1; S_AXI_RREADY in 1.
- reg_q  out  C_NUM_REGS*DW  flattened RW register contents (RO slots drive 0).
- status_i  in  C_NUM_REGS*DW  status inputs for RO registers.
- wr_pulse  out  C_NUM_REGS  one-cycle pulse when register n is written OKAY.

## Operation
- Index = addr[AW-1:clog2(DW/8)]; low byte-offset bits ignored. AxPROT ignored.
- Write FSM: W_IDLE → W_RESP. In W_IDLE, AWREADY high until AW latched, WREADY high until W latched; either order or same cycle. Once both latched: commit, assert BVALID, enter W_RESP. W_RESP → W_IDLE on BVALID&BREADY.
- Commit: index < C_NUM_REGS and not RO → update bytes where WSTRB=1, BRESP=OKAY, wr_pulse[idx]=1. RO target → no update, BRESP=OKAY, no pulse. Index ≥ C_NUM_REGS → no update, BRESP=SLVERR(2'b10). WSTRB=0 → OKAY, no change, pulse still fires.
- Read FSM: R_IDLE → R_DATA. ARREADY high in R_IDLE. On AR handshake capture RDATA (RW value, status_i slice, or 0 if out of range with RRESP=SLVERR), assert RVALID. R_DATA → R_IDLE on RVALID&RREADY. RDATA/RRESP stable while RVALID high.
- Read and write channels independent; may be active simultaneously.

## Timing
- Reset: AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse = 0; BRESP, RRESP, RDATA = 0; RW regs = C_RESET_VAL. First cycle after reset release: AWREADY, WREADY, ARREADY = 1.
- AW and W same cycle: register updated and BVALID = 1 at next edge; wr_pulse high for that same single cycle.
- Read latency: RVALID one cycle after AR handshake.
- Write and read to same register at same edge: read returns pre-write value.
- status_i sampled only at AR handshake; no synchronisation inside block.
- BREADY/RREADY held low: BVALID/RVALID hold indefinitely; no further AW/W/AR accepted on that channel.
- Reset mid-transaction: outstanding handshakes dropped, FSMs to idle, no response issued.
- Throughput: one write per 2 cycles, one read per 2 cycles with ready always high.

## Structure
- Package axil_regbank_pkg: RESP_OKAY/RESP_SLVERR constants, write/read state enums, index-width function.
- Sub-module axil_regbank_wr (write FSM + commit); read path inline in top.

## Test plan
- Write 0x1,0x2,0x3,0x4 to offsets 0x0–0xC, read back -> RDATA equal, RRESP=OKAY, wr_pulse fires once per write.
- WSTRB=4'b0010, WDATA=0xAABBCCDD onto reg holding 0x11223344 -> reads 0x1122CC44.
- C_RO_MASK=8'h80, status_i slot 7=0xDEADBEEF; write 0x5 to 0x1C -> BRESP=OKAY, read 0xDEADBEEF, no pulse.
- C_NUM_REGS=6, access 0x18 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, regs unchanged.
- W before AW by 3 cycles, BREADY low 5 cycles -> one commit, BVALID held, AWREADY/WREADY low until BREADY.
- Assert S_AXI_ARESET while RVALID high -> RVALID=0 immediately, regs=C_RESET_VAL.
